ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
Instruction fetch initiator that drives the word-addressed instruction memory. The memory returns read data combinationally in the same cycle. The block owns the program counter and issues one sequential fetch per cycle. Fetched {pc, instruction} pairs are buffered in a small prefetch FIFO and handed to decode with a valid/ready handshake. Branch/jump redirects from execute flush the buffer and restart fetch at the new target.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, prefetch FIFO entries (power of two, ≥2)
XLEN, 32, address/instruction width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
o_imem_addr  output  XLEN  fetch address to instruction memory, bits [1:0] always 0
i_imem_data  input  XLEN  instruction word, valid combinationally for current o_imem_addr
i_redirect_valid  input  1  flush and restart fetch this cycle
i_redirect_pc  input  XLEN  restart target
o_inst_valid  output  1  FIFO head valid
o_inst  output  XLEN  FIFO head instruction; NOP (32'h0000_0013) when not valid
o_inst_pc  output  XLEN  FIFO head PC; 0 when not valid
i_inst_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset, when rst=1 at a clock edge:
  - pc<=RESET_PC, FIFO count<=0, o_inst_valid=0, o_inst=NOP, o_inst_pc=0.
  - Reset mid-operation discards all buffered entries, with no partial handshake.
- o_imem_addr = {pc[XLEN-1:2],2'b00}, combinational from the pc register.
- pop = o_inst_valid & i_inst_ready.
- push = ~i_redirect_valid & (count<DEPTH | pop).
  - Push and pop in the same cycle is legal when the FIFO is full; count is then unchanged.
- On push: the entry {o_imem_addr, i_imem_data} is written at the tail and pc<=pc+4.
- pc wraps modulo 2^XLEN: 32'hFFFF_FFFC -> 32'h0000_0000.
- No push (full with no pop): pc and o_imem_addr hold. The memory read is repeated and is harmless.
- Redirect (i_redirect_valid=1):
  - FIFO flushed (count<=0), pc<={i_redirect_pc[XLEN-1:2],2'b00}, no push, no pop this cycle.
  - The head entry is not consumed even if i_inst_ready=1.
  - Redirect has priority over push, pop and full.
- Latency:
  - Address is presented cycle N (after reset release or redirect); instruction is at the head with o_inst_valid=1 in cycle N+1.
  - Steady-state throughput is 1 instruction/cycle when decode is always ready.
- Outputs o_inst/o_inst_pc/o_inst_valid come from FIFO head registers/storage. They have no combinational path from i_imem_data or i_inst_ready.
- Back-to-back redirects: each one restarts pc. Only the last target's instructions appear.
- Empty FIFO with i_inst_ready=1: no effect.

Decomposition:
- Package rv_pkg:
  - XLEN=32, INST_W=32, NOP_INST=32'h0000_0013.
  - typedef fetch_entry_t {pc, inst}.
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t with parameter DEPTH.
  - Ports: push, pop, flush, full, empty, head.
  - flush has priority over push/pop.
- ifu_fetch holds the pc register, push/pop/redirect logic and output muxing.

Test Plan:
- Reset release, RESET_PC=0, ready=1, imem model mem[i]=32'h1000_0000+i -> o_imem_addr 0,4,8…; cycle 1 after reset: valid=1, inst=32'h1000_0000, pc=0; then one instruction per cycle in order.
- ready=0 for 5 cycles after reset -> exactly 2 entries (pc 0,4) buffered; o_imem_addr holds 8; on ready=1 the output is pc 0,4,8,12 with no gaps or duplicates.
- Full FIFO with ready=1 and simultaneous push -> count stays 2; ordering is preserved.
- Redirect to 32'h0000_0102 while FIFO full and ready=1 -> next cycle valid=0, o_imem_addr=32'h100; following cycle inst=mem[0x40], pc=32'h100; old entries are never output.
- Redirect to 32'hFFFF_FFF8, ready=1 -> output pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst asserted mid-stream with valid=1 -> next cycle valid=0, inst=NOP, pc=0, o_imem_addr=RESET_PC.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | rv_pkg : shared widths, NOP encoding and fetch entry type          |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fetch_fifo : synchronous prefetch FIFO, flush beats push/pop       |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]    count_q,  count_d;
  logic           do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: empty_o masks stale contents.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | ifu_fetch : PC owner, sequential fetch into prefetch FIFO, redirect|
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module ifu_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic [XLEN-1:0] i_imem_data,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_inst_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  input  logic            i_inst_ready
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            push, pop, fifo_full, fifo_empty;
  fetch_entry_t    head, entry;

  assign o_imem_addr = pc_q & ALIGN_MASK;

  assign pop  = o_inst_valid & i_inst_ready & ~i_redirect_valid;
  assign push = ~i_redirect_valid & (~fifo_full | pop);

  assign entry.pc   = o_imem_addr;
  assign entry.inst = i_imem_data;

  always_comb begin
    pc_d = pc_q;
    if (i_redirect_valid) pc_d = i_redirect_pc & ALIGN_MASK;
    else if (push)        pc_d = o_imem_addr + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC & ALIGN_MASK;
    else     pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (i_redirect_valid),
    .push_i  (push),
    .entry_i (entry),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  // Idle outputs read as a harmless NOP at pc 0 so decode never sees stale data.
  assign o_inst_valid = ~fifo_empty;
  assign o_inst       = o_inst_valid ? head.inst : NOP_INST;
  assign o_inst_pc    = o_inst_valid ? head.pc   : '0;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_ifu_fetch : scoreboard bench for ifu_fetch                      |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_data;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready = 1'b0;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign i_imem_data = mem_word(o_imem_addr);

  ifu_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2),
    .XLEN     (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .o_imem_addr      (o_imem_addr),
    .i_imem_data      (i_imem_data),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .i_inst_ready     (i_inst_ready)
  );

  // Scoreboard: every accepted handshake must match the next expected pc.
  always @(negedge clk) begin
    if (!rst && !i_redirect_valid && o_inst_valid && i_inst_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got pc=%h inst=%h, required no output", o_inst_pc, o_inst);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (o_inst_pc !== e || o_inst !== mem_word(e)) begin
          bad++;
          $display("FAIL sb_order: got pc=%h inst=%h, required pc=%h inst=%h",
                   o_inst_pc, o_inst, e, mem_word(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d pending, required 0", name, exp_q.size());
    end
    i_inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_inst_ready = 1'b1; i_redirect_valid = 1'b0;
    tick(); tick();
    total += 4;
    if (o_inst_valid !== 1'b0)         begin bad++; $display("FAIL rst_valid: got %b required 0", o_inst_valid); end
    if (o_inst !== 32'h0000_0013)      begin bad++; $display("FAIL rst_inst: got %h required 00000013", o_inst); end
    if (o_inst_pc !== 32'h0)           begin bad++; $display("FAIL rst_pc: got %h required 0", o_inst_pc); end
    if (o_imem_addr !== 32'h0)         begin bad++; $display("FAIL rst_addr: got %h required 0", o_imem_addr); end
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      total += 2;
      if (o_inst_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b required 1", k, o_inst_valid); end
      if (o_imem_addr !== 32'((k + 1) * 4)) begin
        bad++; $display("FAIL stream_addr[%0d]: got %h required %h", k, o_imem_addr, 32'((k + 1) * 4));
      end
      if (k == 0) begin
        total++;
        if (o_inst !== 32'h1000_0000 || o_inst_pc !== 32'h0) begin
          bad++; $display("FAIL first_inst: got pc=%h inst=%h required pc=0 inst=10000000", o_inst_pc, o_inst);
        end
      end
    end
    drain("stream");
  endtask

  task automatic test_backpressure();
    rst = 1'b1; i_inst_ready = 1'b0;
    tick();
    exp_q.delete();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    total += 2;
    if (o_imem_addr !== 32'h8) begin bad++; $display("FAIL bp_hold_addr: got %h required 8", o_imem_addr); end
    if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h0) begin
      bad++; $display("FAIL bp_head: got valid=%b pc=%h required valid=1 pc=0", o_inst_valid, o_inst_pc);
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    i_inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (o_inst_valid !== 1'b1) begin bad++; $display("FAIL bp_gap[%0d]: got %b required 1", k, o_inst_valid); end
      if (k == 0) begin
        total++;
        if (o_imem_addr !== 32'hC || o_inst_pc !== 32'h4) begin
          bad++; $display("FAIL full_pushpop: got addr=%h pc=%h required addr=c pc=4", o_imem_addr, o_inst_pc);
        end
      end
    end
    drain("bp");
  endtask

  task automatic test_redirect_full();
    rst = 1'b1; i_inst_ready = 1'b0;
    tick();
    exp_q.delete();
    rst = 1'b0;
    tick(); tick(); tick();
    i_inst_ready = 1'b1; i_redirect_valid = 1'b1; i_redirect_pc = 32'h0000_0102;
    tick();
    i_redirect_valid = 1'b0;
    total += 2;
    if (o_inst_valid !== 1'b0 || o_inst !== 32'h13 || o_inst_pc !== 32'h0) begin
      bad++; $display("FAIL redir_flush: got valid=%b inst=%h pc=%h required 0/00000013/0", o_inst_valid, o_inst, o_inst_pc);
    end
    if (o_imem_addr !== 32'h100) begin bad++; $display("FAIL redir_addr: got %h required 100", o_imem_addr); end
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    tick();
    total++;
    if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h100 || o_inst !== 32'h1000_0040) begin
      bad++; $display("FAIL redir_first: got valid=%b pc=%h inst=%h required 1/100/10000040", o_inst_valid, o_inst_pc, o_inst);
    end
    drain("redir");
  endtask

  task automatic test_back_to_back();
    i_inst_ready = 1'b1;
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h200;
    tick();
    i_redirect_pc = 32'h300;
    tick();
    total++;
    if (o_inst_valid !== 1'b0 || o_imem_addr !== 32'h300) begin
      bad++; $display("FAIL b2b_redir: got valid=%b addr=%h required 0/300", o_inst_valid, o_imem_addr);
    end
    i_redirect_pc = 32'hFFFF_FFF8;
    tick();
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);         exp_q.push_back(32'h4);
    i_redirect_valid = 1'b0;
    total++;
    if (o_imem_addr !== 32'hFFFF_FFF8 || o_inst_valid !== 1'b0) begin
      bad++; $display("FAIL wrap_start: got addr=%h valid=%b required fffffff8/0", o_imem_addr, o_inst_valid);
    end
    tick();
    total++;
    if (o_inst_pc !== 32'hFFFF_FFF8 || o_imem_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_step1: got pc=%h addr=%h required fffffff8/fffffffc", o_inst_pc, o_imem_addr);
    end
    tick();
    total++;
    if (o_imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr: got %h required 0", o_imem_addr); end
    drain("wrap");
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1; i_inst_ready = 1'b0;
    tick();
    exp_q.delete();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    rst = 1'b0; i_inst_ready = 1'b1;
    tick(); tick(); tick();
    total++;
    if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h8) begin
      bad++; $display("FAIL mid_pre: got valid=%b pc=%h required 1/8", o_inst_valid, o_inst_pc);
    end
    rst = 1'b1;
    exp_q.delete();
    tick();
    total += 2;
    if (o_inst_valid !== 1'b0 || o_inst !== 32'h13 || o_inst_pc !== 32'h0) begin
      bad++; $display("FAIL mid_rst_out: got valid=%b inst=%h pc=%h required 0/00000013/0", o_inst_valid, o_inst, o_inst_pc);
    end
    if (o_imem_addr !== 32'h0) begin bad++; $display("FAIL mid_rst_addr: got %h required 0", o_imem_addr); end
    rst = 1'b0; i_inst_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect_full();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
